// File: rtl/hex_tx_formatter.sv
// Prints a WIDTH-bit value as uppercase ASCII hex (MSB nibble first, optional CR LF)
// one byte at a time into a uart_tx style data/strobe/ready handshake.
module hex_tx_formatter #(
  parameter int WIDTH   = 32,
  parameter int NEWLINE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] value,
  input  logic             value_strobe,
  output logic             busy,
  output logic [7:0]       tx_data,
  output logic             tx_strobe,
  input  logic             tx_ready
);

  localparam int N_DIG = WIDTH / 4;
  localparam int N_CHR = N_DIG + 2 * NEWLINE;
  localparam int IW    = $clog2(N_CHR + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_CHR - 1);
  localparam logic [IW-1:0] CR_IDX   = IW'(N_DIG);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IW-1:0]    idx_r;
  logic [IW-1:0]    idx_nxt_s;
  logic [WIDTH-1:0] value_r;
  logic [WIDTH-1:0] value_nxt_s;
  logic             busy_nxt_s;
  logic [7:0]       tx_data_nxt_s;
  logic             tx_strobe_nxt_s;
  logic [7:0]       char_s;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) begin
      res = {4'h3, nib};
    end else begin
      res = 8'h37 + {4'h0, nib};
    end
    return res;
  endfunction

  // Current character: the latched value is shifted left per digit, so its top nibble is always next.
  always_comb begin
    char_s = 8'h00;
    if (idx_r < CR_IDX) begin
      char_s = hex_ascii(value_r[WIDTH-1 -: 4]);
    end else if (idx_r == CR_IDX) begin
      char_s = 8'h0D;
    end else begin
      char_s = 8'h0A;
    end
  end

  // Next-state and next-output logic; HOLD spans the cycle tx_strobe is high so tx_ready is not sampled there.
  always_comb begin
    state_nxt_s     = state_r;
    idx_nxt_s       = idx_r;
    value_nxt_s     = value_r;
    busy_nxt_s      = busy;
    tx_data_nxt_s   = tx_data;
    tx_strobe_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (value_strobe && !busy) begin
          value_nxt_s = value;
          idx_nxt_s   = '0;
          busy_nxt_s  = 1'b1;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_data_nxt_s   = char_s;
          tx_strobe_nxt_s = 1'b1;
          state_nxt_s     = HOLD;
        end else begin
          state_nxt_s = SEND;
        end
      end
      HOLD: begin
        if (idx_r == LAST_IDX) begin
          idx_nxt_s   = '0;
          busy_nxt_s  = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          idx_nxt_s   = idx_r + ONE_IDX;
          value_nxt_s = value_r << 3'd4;
          state_nxt_s = SEND;
        end
      end
      default: begin
        idx_nxt_s   = '0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, index, latched value and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      value_r   <= '0;
      busy      <= 1'b0;
      tx_data   <= 8'h00;
      tx_strobe <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      value_r   <= value_nxt_s;
      busy      <= busy_nxt_s;
      tx_data   <= tx_data_nxt_s;
      tx_strobe <= tx_strobe_nxt_s;
    end
  end

endmodule

// File: tb/tb_hex_tx_formatter.sv
// Bench for hex_tx_formatter: a 32-bit/CRLF instance and an 8-bit/no-newline instance,
// checked against hand-derived tables and an arithmetic hex-printing model.
module tb_hex_tx_formatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] value_a;
  logic        vs_a, busy_a, txs_a, rdy_a;
  logic [7:0]  txd_a;
  logic [7:0]  value_b;
  logic        vs_b, busy_b, txs_b, rdy_b;
  logic [7:0]  txd_b;

  hex_tx_formatter #(.WIDTH(32), .NEWLINE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .value(value_a), .value_strobe(vs_a),
    .busy(busy_a), .tx_data(txd_a), .tx_strobe(txs_a), .tx_ready(rdy_a)
  );

  hex_tx_formatter #(.WIDTH(8), .NEWLINE(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .value(value_b), .value_strobe(vs_b),
    .busy(busy_b), .tx_data(txd_b), .tx_strobe(txs_b), .tx_ready(rdy_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap_a[$];
  logic [7:0] cap_b[$];
  int         ccyc_a[$];
  int         ccyc_b[$];
  logic [7:0] exp_q[$];

  // Record every strobed byte together with the cycle it appeared in.
  always @(negedge clk) begin
    if (txs_a) begin
      cap_a.push_back(txd_a);
      ccyc_a.push_back(cyc);
    end
    if (txs_b) begin
      cap_b.push_back(txd_b);
      ccyc_b.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: hex digits by plain division into nibbles, then CR LF.
  task automatic model_append(input logic [63:0] v, input int width, input int nl);
    int nd = width / 4;
    for (int i = 0; i < nd; i++) begin
      int nib = int'((v >> (4 * (nd - 1 - i))) % 64'd16);
      exp_q.push_back((nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
    end
    if (nl != 0) begin
      exp_q.push_back(8'd13);
      exp_q.push_back(8'd10);
    end
  endtask

  task automatic clear_caps();
    cap_a.delete(); cap_b.delete(); ccyc_a.delete(); ccyc_b.delete();
  endtask

  function automatic int cap_size(input int sel);
    return (sel == 0) ? cap_a.size() : cap_b.size();
  endfunction

  function automatic logic [7:0] cap_byte(input int sel, input int i);
    return (sel == 0) ? cap_a[i] : cap_b[i];
  endfunction

  function automatic int cap_cyc(input int sel, input int i);
    return (sel == 0) ? ccyc_a[i] : ccyc_b[i];
  endfunction

  task automatic start(input int sel, input logic [31:0] v, output int base);
    if (sel == 0) begin value_a = v; vs_a = 1'b1; end
    else begin value_b = v[7:0]; vs_b = 1'b1; end
    base = cyc;
    tick();
    vs_a = 1'b0; vs_b = 1'b0;
    value_a = $urandom; value_b = 8'($urandom);
  endtask

  task automatic wait_idle(input int sel, input string name, output int fell);
    int n = 0;
    while (((sel == 0) ? busy_a : busy_b) && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, {63'd0, (sel == 0) ? busy_a : busy_b}, 64'd0);
    fell = cyc;
  endtask

  task automatic wait_caps(input int sel, input int n, input string name);
    int k = 0;
    while (cap_size(sel) < n && k < 300) begin
      tick();
      k++;
    end
    chk({name, "_reach"}, 64'(cap_size(sel)), 64'(n));
  endtask

  // Compare captured bytes from position off onward with exp_q; strobes every 2 cycles from base+2.
  task automatic check_str(input int sel, input string name, input int off, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (off + i < cap_size(sel)) begin
        chk($sformatf("%s_byte%0d", name, i), 64'(cap_byte(sel, off + i)), 64'(exp_q[i]));
        chk($sformatf("%s_cyc%0d", name, i), 64'(cap_cyc(sel, off + i)), 64'(base + 2 + 2 * i));
      end else begin
        chk($sformatf("%s_missing%0d", name, i), 64'(cap_size(sel)), 64'(off + exp_q.size()));
      end
    end
  endtask

  typedef struct {
    int          sel;
    logic [31:0] value;
    int          nbytes;
    logic [79:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int base, fell, r, bad, sel, base2;
    logic [31:0] v;

    tbl[0] = '{0, 32'hDEADBEEF, 10, 80'h44454144424545460D0A};
    tbl[1] = '{0, 32'h12345678, 10, 80'h31323334353637380D0A};
    tbl[2] = '{0, 32'h0F1E2D3C, 10, 80'h30463145324433430D0A};
    tbl[3] = '{1, 32'h0000000A,  2, 80'h3041};
    tbl[4] = '{1, 32'h000000FF,  2, 80'h4646};
    tbl[5] = '{1, 32'h00000000,  2, 80'h3030};
    tbl[6] = '{1, 32'h0000005C,  2, 80'h3543};

    reset_n = 1'b0;
    value_a = 32'd0; vs_a = 1'b0; rdy_a = 1'b1;
    value_b = 8'd0;  vs_b = 1'b0; rdy_b = 1'b1;
    #2;
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_strobe", {63'd0, txs_a}, 64'd0);
    chk("rst_data", {56'd0, txd_a}, 64'd0);
    chk("rst_busy_b", {63'd0, busy_b}, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Table of hand-derived strings.
    for (int t = 0; t < 7; t++) begin
      clear_caps();
      exp_q.delete();
      for (int j = 0; j < tbl[t].nbytes; j++) exp_q.push_back(tbl[t].exp[8 * (tbl[t].nbytes - 1 - j) +: 8]);
      start(tbl[t].sel, tbl[t].value, base);
      wait_idle(tbl[t].sel, $sformatf("tbl%0d", t), fell);
      chk($sformatf("tbl%0d_count", t), 64'(cap_size(tbl[t].sel)), 64'(tbl[t].nbytes));
      check_str(tbl[t].sel, $sformatf("tbl%0d", t), 0, base);
      chk($sformatf("tbl%0d_busyfall", t), 64'(fell), 64'(base + 2 * tbl[t].nbytes + 1));
      tick();
    end

    // Random values against the model.
    for (int t = 0; t < 16; t++) begin
      sel = t % 2;
      v = $urandom;
      if (sel == 1) v = v & 32'h000000FF;
      clear_caps();
      exp_q.delete();
      model_append({32'd0, v}, (sel == 0) ? 32 : 8, (sel == 0) ? 1 : 0);
      start(sel, v, base);
      wait_idle(sel, $sformatf("rnd%0d", t), fell);
      chk($sformatf("rnd%0d_count", t), 64'(cap_size(sel)), 64'(exp_q.size()));
      check_str(sel, $sformatf("rnd%0d", t), 0, base);
      chk($sformatf("rnd%0d_busyfall", t), 64'(fell), 64'(base + 2 * exp_q.size() + 1));
    end

    // Backpressure after the 3rd byte.
    clear_caps();
    exp_q.delete();
    model_append(64'hDEADBEEF, 32, 1);
    start(0, 32'hDEADBEEF, base);
    wait_caps(0, 3, "bp");
    rdy_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txs_a || txd_a !== 8'h41) bad++;
    end
    chk("bp_stall_violations", 64'(bad), 64'd0);
    chk("bp_stall_count", 64'(cap_a.size()), 64'd3);
    rdy_a = 1'b1;
    r = cyc;
    wait_idle(0, "bp", fell);
    chk("bp_count", 64'(cap_a.size()), 64'd10);
    for (int i = 0; i < 10 && i < cap_a.size(); i++) begin
      chk($sformatf("bp_byte%0d", i), 64'(cap_a[i]), 64'(exp_q[i]));
      chk($sformatf("bp_cyc%0d", i), 64'(ccyc_a[i]), (i < 3) ? 64'(base + 2 + 2 * i) : 64'(r + 1 + 2 * (i - 3)));
    end

    // value_strobe during an active print is ignored.
    tick();
    clear_caps();
    start(0, 32'hDEADBEEF, base);
    wait_caps(0, 2, "ign");
    value_a = 32'h12345678; vs_a = 1'b1;
    tick();
    vs_a = 1'b0;
    wait_idle(0, "ign", fell);
    for (int i = 0; i < 20; i++) tick();
    chk("ign_count", 64'(cap_a.size()), 64'd10);
    check_str(0, "ign", 0, base);

    // Reset in the middle of a string.
    clear_caps();
    start(0, 32'hCAFEF00D, base);
    wait_caps(0, 5, "rst");
    chk("rst_pre_strobe", {63'd0, txs_a}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_strobe", {63'd0, txs_a}, 64'd0);
    chk("rst_async_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_async_data", {56'd0, txd_a}, 64'd0);
    tick(); tick(); tick();
    reset_n = 1'b1;
    clear_caps();
    for (int i = 0; i < 30; i++) tick();
    chk("rst_after_count", 64'(cap_a.size()), 64'd0);
    chk("rst_after_busy", {63'd0, busy_a}, 64'd0);

    // Strobe in the cycle busy falls is ignored; one cycle later it is accepted.
    clear_caps();
    exp_q.delete();
    model_append(64'hDEADBEEF, 32, 1);
    start(0, 32'hDEADBEEF, base);
    wait_caps(0, 10, "b2b");
    value_a = 32'h12345678; vs_a = 1'b1;
    tick();
    chk("b2b_busy_fell", {63'd0, busy_a}, 64'd0);
    value_a = 32'h0F1E2D3C;
    base2 = cyc;
    tick();
    vs_a = 1'b0;
    wait_idle(0, "b2b", fell);
    chk("b2b_count", 64'(cap_a.size()), 64'd20);
    check_str(0, "b2b_first", 0, base);
    exp_q.delete();
    model_append(64'h0F1E2D3C, 32, 1);
    check_str(0, "b2b_second", 10, base2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
